// File: rtl/sram_pixel_reader_pkg.sv
// Shared types and constants for the SRAM frame-buffer pixel reader.
package sram_pixel_reader_pkg;

   localparam int SRAM_AW   = 20;
   localparam int SRAM_DW   = 16;
   localparam int PIX_CNT_W = 17;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_STALL   = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   typedef struct packed {
      logic [4:0] red;
      logic [5:0] green;
      logic [4:0] blue;
   } rgb565_t;

   // One FIFO entry: pixel plus frame-boundary sidebands.
   typedef struct packed {
      rgb565_t pixel;
      logic    sop;
      logic    eop;
   } fifo_word_t;

endpackage

// File: rtl/sram_pixel_reader_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count, plus the
// checker that flags any push into a full FIFO.
module sync_fifo_fwft #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int                AW         = $clog2(DEPTH);
   localparam logic [AW:0]       FULL_LEVEL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]       ZERO_LEVEL = {(AW + 1){1'b0}};
   localparam logic [AW:0]       ONE_LEVEL  = (AW + 1)'(1);
   localparam logic [AW-1:0]     PTR_ONE    = AW'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             wr_en_s;
   logic             rd_en_s;

   // A full FIFO drops the push so storage is never corrupted.
   assign wr_en_s = push && !full;
   assign rd_en_s = pop && !empty;
   assign full    = (count_r == FULL_LEVEL);
   assign empty   = (count_r == ZERO_LEVEL);
   assign count   = count_r;
   assign rdata   = mem_r[rd_ptr_r];

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= ZERO_LEVEL;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + ONE_LEVEL;
            2'b01:   count_r <= count_r - ONE_LEVEL;
            default: count_r <= count_r;
         endcase
      end
   end

   sync_fifo_fwft_checker u_checker (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .full  (full)
   );

endmodule

module sync_fifo_fwft_checker (
   input logic clk,
   input logic reset,
   input logic push,
   input logic full
);

   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/sram_pixel_reader.sv
// Reads one frame of 16-bit words from an asynchronous SRAM at two clocks per
// word and streams them downstream as RGB565 pixels with sop/eop markers.
module sram_pixel_reader
   import sram_pixel_reader_pkg::*;
#(
   parameter int                 FRAME_W    = 320,
   parameter int                 FRAME_H    = 240,
   parameter logic [SRAM_AW-1:0] BUF_STRIDE = 20'h13000,
   parameter int                 FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               buf_sel,
   output logic               busy,
   output logic               done,
   output logic [SRAM_AW-1:0] sram_ADDR,
   inout  wire  [SRAM_DW-1:0] sram_DQ,
   output logic               sram_CE_N,
   output logic               sram_OE_N,
   output logic               sram_WE_N,
   output logic               sram_LB_N,
   output logic               sram_UB_N,
   output logic [SRAM_DW-1:0] px_data,
   output logic               px_valid,
   input  logic               px_ready,
   output logic               px_sop,
   output logic               px_eop
);

   localparam int                   TOTAL_PIX   = FRAME_W * FRAME_H;
   localparam logic [PIX_CNT_W-1:0] LAST_PIX    = PIX_CNT_W'(TOTAL_PIX - 1);
   localparam logic [PIX_CNT_W-1:0] PIX_ZERO    = {PIX_CNT_W{1'b0}};
   localparam logic [PIX_CNT_W-1:0] PIX_ONE     = PIX_CNT_W'(1);
   localparam logic [SRAM_AW-1:0]   ADDR_ZERO   = {SRAM_AW{1'b0}};
   localparam logic [SRAM_AW-1:0]   ADDR_ONE    = SRAM_AW'(1);
   localparam int                   CNT_W       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0]     STALL_LEVEL = CNT_W'(FIFO_DEPTH - 1);

   if (TOTAL_PIX < 1 || TOTAL_PIX > 131071) begin : g_bad_frame_size
      $error("sram_pixel_reader: FRAME_W*FRAME_H must lie in 1..131071");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("sram_pixel_reader: FIFO_DEPTH must be a power of two >= 2");
   end

   state_t                 state_r;
   state_t                 state_s;
   logic [SRAM_AW-1:0]     addr_r;
   logic [SRAM_AW-1:0]     addr_s;
   logic [PIX_CNT_W-1:0]   pix_cnt_r;
   logic [PIX_CNT_W-1:0]   pix_cnt_s;
   logic                   done_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   last_word_s;
   fifo_word_t             wdata_s;
   fifo_word_t             head_s;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;
   logic [SRAM_AW-1:0]     sram_addr_r;
   logic                   sram_en_n_r;
   logic                   busy_r;
   logic                   done_r;

   // Read-only port: the data bus is never driven from this side.
   assign sram_DQ   = {SRAM_DW{1'bz}};
   assign sram_WE_N = 1'b1;
   assign sram_ADDR = sram_addr_r;
   assign sram_CE_N = sram_en_n_r;
   assign sram_OE_N = sram_en_n_r;
   assign sram_LB_N = sram_en_n_r;
   assign sram_UB_N = sram_en_n_r;

   assign last_word_s   = (pix_cnt_r == LAST_PIX);
   assign wdata_s.pixel = rgb565_t'(sram_DQ);
   assign wdata_s.sop   = (pix_cnt_r == PIX_ZERO);
   assign wdata_s.eop   = last_word_s;

   // Next-state, address and pixel-count logic.
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      pix_cnt_s = pix_cnt_r;
      done_s    = 1'b0;
      push_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // done_r is high in the first idle cycle, so a start there is dropped.
            if (start && !done_r) begin
               addr_s    = buf_sel ? BUF_STRIDE : ADDR_ZERO;
               pix_cnt_s = PIX_ZERO;
               state_s   = ST_SETUP;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_s = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            push_s    = 1'b1;
            addr_s    = addr_r + ADDR_ONE;
            pix_cnt_s = pix_cnt_r + PIX_ONE;
            // The word pushed now is in flight, so stall one entry early.
            if (last_word_s) begin
               state_s = ST_DRAIN;
            end else if (fifo_count >= STALL_LEVEL) begin
               state_s = ST_STALL;
            end else begin
               state_s = ST_SETUP;
            end
         end
         ST_STALL: begin
            if (!fifo_full) begin
               state_s = ST_SETUP;
            end else begin
               state_s = ST_STALL;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               state_s = ST_IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, address and pixel counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         addr_r    <= ADDR_ZERO;
         pix_cnt_r <= PIX_ZERO;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         pix_cnt_r <= pix_cnt_s;
      end
   end

   // Registered SRAM pins: enabled across each SETUP/CAPTURE pair only.
   always_ff @(posedge clk) begin
      if (reset) begin
         sram_addr_r <= ADDR_ZERO;
         sram_en_n_r <= 1'b1;
      end else begin
         if (state_s == ST_SETUP) begin
            sram_addr_r <= addr_s;
         end else begin
            sram_addr_r <= sram_addr_r;
         end
         sram_en_n_r <= !((state_s == ST_SETUP) || (state_s == ST_CAPTURE));
      end
   end

   // Frame status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s != ST_IDLE);
         done_r <= done_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;

   sync_fifo_fwft #(
      .WIDTH ($bits(fifo_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .wdata (wdata_s),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign px_valid = !fifo_empty;
   assign pop_s    = px_valid && px_ready;
   assign px_data  = head_s.pixel;
   assign px_sop   = px_valid && head_s.sop;
   assign px_eop   = px_valid && head_s.eop;

endmodule

// File: tb/tb_sram_pixel_reader.sv
// Directed bench: three reader instances (4x2, 8x4, 2x2 at base FFFFE) share
// a clock and reset; each SRAM is modelled as a fixed function of address.
module tb_sram_pixel_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  start;
   logic [2:0]  px_ready;
   logic        buf_sel;

   wire  [19:0] addr_w  [3];
   wire  [15:0] data_w  [3];
   wire         busy_w  [3];
   wire         done_w  [3];
   wire         ce_w    [3];
   wire         oe_w    [3];
   wire         we_w    [3];
   wire         lb_w    [3];
   wire         ub_w    [3];
   wire         valid_w [3];
   wire         sop_w   [3];
   wire         eop_w   [3];
   wire  [15:0] dq0;
   wire  [15:0] dq1;
   wire  [15:0] dq2;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          rx_cnt   [3];
   int          addr_cnt [3];
   int          done_cnt [3];
   bit          phase    [3];
   logic [17:0] rx_word  [3][64];
   int          rx_cyc   [3][64];
   logic [19:0] addr_log [3][64];

   function automatic logic [15:0] sram_model(input logic [19:0] a);
      return a[15:0] ^ 16'hA5C3 ^ {12'h000, a[19:16]};
   endfunction

   assign dq0 = sram_model(addr_w[0]);
   assign dq1 = sram_model(addr_w[1]);
   assign dq2 = sram_model(addr_w[2]);

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record accepted pixels, done pulses and one address per SETUP/CAPTURE pair.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset && valid_w[i] && px_ready[i]) begin
            rx_word[i][rx_cnt[i] % 64] <= {data_w[i], sop_w[i], eop_w[i]};
            rx_cyc[i][rx_cnt[i] % 64]  <= cyc;
            rx_cnt[i] <= rx_cnt[i] + 1;
         end
         if (!reset && done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
         if (ce_w[i] == 1'b0) begin
            if (!phase[i]) begin
               addr_log[i][addr_cnt[i] % 64] <= addr_w[i];
               addr_cnt[i] <= addr_cnt[i] + 1;
            end
            phase[i] <= !phase[i];
         end else begin
            phase[i] <= 1'b0;
         end
      end
   end

   sram_pixel_reader #(.FRAME_W(4), .FRAME_H(2), .BUF_STRIDE(20'h13000), .FIFO_DEPTH(16)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .buf_sel(buf_sel), .busy(busy_w[0]), .done(done_w[0]),
      .sram_ADDR(addr_w[0]), .sram_DQ(dq0), .sram_CE_N(ce_w[0]), .sram_OE_N(oe_w[0]), .sram_WE_N(we_w[0]),
      .sram_LB_N(lb_w[0]), .sram_UB_N(ub_w[0]), .px_data(data_w[0]), .px_valid(valid_w[0]),
      .px_ready(px_ready[0]), .px_sop(sop_w[0]), .px_eop(eop_w[0]));

   sram_pixel_reader #(.FRAME_W(8), .FRAME_H(4), .BUF_STRIDE(20'h13000), .FIFO_DEPTH(16)) u1 (
      .clk(clk), .reset(reset), .start(start[1]), .buf_sel(buf_sel), .busy(busy_w[1]), .done(done_w[1]),
      .sram_ADDR(addr_w[1]), .sram_DQ(dq1), .sram_CE_N(ce_w[1]), .sram_OE_N(oe_w[1]), .sram_WE_N(we_w[1]),
      .sram_LB_N(lb_w[1]), .sram_UB_N(ub_w[1]), .px_data(data_w[1]), .px_valid(valid_w[1]),
      .px_ready(px_ready[1]), .px_sop(sop_w[1]), .px_eop(eop_w[1]));

   sram_pixel_reader #(.FRAME_W(2), .FRAME_H(2), .BUF_STRIDE(20'hFFFFE), .FIFO_DEPTH(16)) u2 (
      .clk(clk), .reset(reset), .start(start[2]), .buf_sel(buf_sel), .busy(busy_w[2]), .done(done_w[2]),
      .sram_ADDR(addr_w[2]), .sram_DQ(dq2), .sram_CE_N(ce_w[2]), .sram_OE_N(oe_w[2]), .sram_WE_N(we_w[2]),
      .sram_LB_N(lb_w[2]), .sram_UB_N(ub_w[2]), .px_data(data_w[2]), .px_valid(valid_w[2]),
      .px_ready(px_ready[2]), .px_sop(sop_w[2]), .px_eop(eop_w[2]));

   task automatic start_frame(input int i, input logic bsel);
      @(posedge clk); #1;
      buf_sel  = bsel;
      start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int max_cyc, output bit ok);
      for (int n = 0; n < max_cyc && busy_w[i]; n++) begin
         @(posedge clk); #1;
      end
      ok = !busy_w[i];
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({busy_w[i], done_w[i], valid_w[i], sop_w[i], eop_w[i]} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_flags[%0d] got=%b exp=00000", i, {busy_w[i], done_w[i], valid_w[i], sop_w[i], eop_w[i]});
         end
         checks++;
         if (addr_w[i] !== 20'h00000) begin
            failures++;
            $display("FAIL reset_addr[%0d] got=%h exp=00000", i, addr_w[i]);
         end
         checks++;
         if ({ce_w[i], oe_w[i], lb_w[i], ub_w[i], we_w[i]} !== 5'b11111) begin
            failures++;
            $display("FAIL reset_sram_ctl[%0d] got=%b exp=11111", i, {ce_w[i], oe_w[i], lb_w[i], ub_w[i], we_w[i]});
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Check one completed frame of n pixels starting at base on instance i.
   task automatic check_frame(input string name, input int i, input int rb, input int ab,
                              input int n, input logic [19:0] base);
      logic [19:0] a;
      logic [17:0] exp;
      checks++;
      if (rx_cnt[i] - rb !== n) begin
         failures++;
         $display("FAIL %s_pixel_count got=%0d exp=%0d", name, rx_cnt[i] - rb, n);
      end
      checks++;
      if (addr_cnt[i] - ab !== n) begin
         failures++;
         $display("FAIL %s_read_count got=%0d exp=%0d", name, addr_cnt[i] - ab, n);
      end
      for (int k = 0; k < n; k++) begin
         a   = base + 20'(k);
         exp = {sram_model(a), (k == 0), (k == n - 1)};
         checks++;
         if (rx_word[i][(rb + k) % 64] !== exp) begin
            failures++;
            $display("FAIL %s_pixel[%0d] got=%h exp=%h", name, k, rx_word[i][(rb + k) % 64], exp);
         end
         checks++;
         if (addr_log[i][(ab + k) % 64] !== a) begin
            failures++;
            $display("FAIL %s_addr[%0d] got=%h exp=%h", name, k, addr_log[i][(ab + k) % 64], a);
         end
      end
   endtask

   task automatic test_basic_frame;
      int rb = rx_cnt[0];
      int ab = addr_cnt[0];
      int db = done_cnt[0];
      bit ok;
      px_ready = 3'b111;
      start_frame(0, 1'b0);
      wait_idle(0, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_timeout busy=%b exp=0", busy_w[0]); end
      check_frame("basic", 0, rb, ab, 8, 20'h00000);
      checks++;
      if (done_cnt[0] - db !== 1) begin
         failures++;
         $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt[0] - db);
      end
      checks++;
      if (rx_cyc[0][(rb + 7) % 64] - rx_cyc[0][rb % 64] !== 14) begin
         failures++;
         $display("FAIL basic_throughput got=%0d exp=14", rx_cyc[0][(rb + 7) % 64] - rx_cyc[0][rb % 64]);
      end
   endtask

   task automatic test_buf_sel1;
      int rb = rx_cnt[0];
      int ab = addr_cnt[0];
      bit ok;
      start_frame(0, 1'b1);
      wait_idle(0, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bufsel_timeout busy=%b exp=0", busy_w[0]); end
      check_frame("bufsel", 0, rb, ab, 8, 20'h13000);
   endtask

   task automatic test_stall;
      int rb = rx_cnt[1];
      int ab = addr_cnt[1];
      int rs;
      bit ok;
      logic [17:0] exp;
      px_ready[1] = 1'b1;
      start_frame(1, 1'b0);
      for (int n = 0; n < 200 && rx_cnt[1] - rb < 4; n++) begin
         @(posedge clk); #1;
      end
      px_ready[1] = 1'b0;
      rs = rx_cnt[1] - rb;
      repeat (40) @(posedge clk);
      @(negedge clk);
      checks++;
      if (u1.fifo_count !== 5'd16) begin
         failures++;
         $display("FAIL stall_fifo_count got=%0d exp=16", u1.fifo_count);
      end
      checks++;
      if (ce_w[1] !== 1'b1) begin
         failures++;
         $display("FAIL stall_ce_n got=%b exp=1", ce_w[1]);
      end
      exp = {sram_model(20'(rs)), 1'b0, 1'b0};
      checks++;
      if ({valid_w[1], data_w[1], sop_w[1], eop_w[1]} !== {1'b1, exp}) begin
         failures++;
         $display("FAIL stall_head got=%h exp=%h", {valid_w[1], data_w[1], sop_w[1], eop_w[1]}, {1'b1, exp});
      end
      @(posedge clk); #1;
      px_ready[1] = 1'b1;
      wait_idle(1, 400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL stall_timeout busy=%b exp=0", busy_w[1]); end
      check_frame("stall", 1, rb, ab, 32, 20'h00000);
   endtask

   task automatic test_back_to_back;
      int rb = rx_cnt[0];
      int ab = addr_cnt[0];
      int db = done_cnt[0];
      bit seen = 1'b0;
      start_frame(0, 1'b0);
      repeat (4) @(posedge clk);
      start_frame(0, 1'b1);
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         seen = done_w[0];
      end
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (!seen) begin failures++; $display("FAIL b2b_done_timeout got=0 exp=1"); end
      check_frame("b2b", 0, rb, ab, 8, 20'h00000);
      checks++;
      if (done_cnt[0] - db !== 1 || busy_w[0] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_single_frame done=%0d busy=%b exp done=1 busy=0", done_cnt[0] - db, busy_w[0]);
      end
   endtask

   task automatic test_reset_mid_frame;
      int rb = rx_cnt[1];
      int db = done_cnt[1];
      int ab;
      bit ok;
      logic [17:0] exp;
      px_ready[1] = 1'b1;
      start_frame(1, 1'b0);
      for (int n = 0; n < 200 && rx_cnt[1] - rb < 5; n++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy_w[1], done_w[1], valid_w[1], sop_w[1], eop_w[1], ce_w[1], oe_w[1], addr_w[1]} !==
          {5'b00000, 2'b11, 20'h00000}) begin
         failures++;
         $display("FAIL midreset_outputs got=%b_%b_%h exp=00000_11_00000",
                  {busy_w[1], done_w[1], valid_w[1], sop_w[1], eop_w[1]}, {ce_w[1], oe_w[1]}, addr_w[1]);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (rx_cnt[1] - rb !== 5 || done_cnt[1] - db !== 0) begin
         failures++;
         $display("FAIL midreset_abandon pixels=%0d done=%0d exp pixels=5 done=0", rx_cnt[1] - rb, done_cnt[1] - db);
      end
      for (int k = 0; k < 5; k++) begin
         exp = {sram_model(20'(k)), (k == 0), 1'b0};
         checks++;
         if (rx_word[1][(rb + k) % 64] !== exp) begin
            failures++;
            $display("FAIL midreset_partial[%0d] got=%h exp=%h", k, rx_word[1][(rb + k) % 64], exp);
         end
      end
      rb = rx_cnt[1];
      ab = addr_cnt[1];
      start_frame(1, 1'b0);
      wait_idle(1, 400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midreset_timeout busy=%b exp=0", busy_w[1]); end
      check_frame("restart", 1, rb, ab, 32, 20'h00000);
   endtask

   task automatic test_addr_wrap;
      int rb = rx_cnt[2];
      int ab = addr_cnt[2];
      int db = done_cnt[2];
      bit ok;
      start_frame(2, 1'b1);
      wait_idle(2, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL wrap_timeout busy=%b exp=0", busy_w[2]); end
      check_frame("wrap", 2, rb, ab, 4, 20'hFFFFE);
      checks++;
      if (done_cnt[2] - db !== 1) begin
         failures++;
         $display("FAIL wrap_done_pulses got=%0d exp=1", done_cnt[2] - db);
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 3'b000;
      px_ready = 3'b111;
      buf_sel  = 1'b0;
      test_reset();
      test_basic_frame();
      test_buf_sel1();
      test_stall();
      test_back_to_back();
      test_reset_mid_frame();
      test_addr_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_pixel_reader.md
SRAM_PIXEL_READER -- requirements
Module: sram_pixel_reader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FRAME_W, 320, pixels per line.
- FRAME_H, 240, lines per frame.
- BUF_STRIDE, 20'h13000, word offset between frame buffer 0 and buffer 1.
- FIFO_DEPTH, 16, output FIFO entries (power of two).

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse that begins a frame read.
- buf_sel, in, 1, frame buffer select, sampled with start.
- busy, out, 1, high from the accepted start until the last pixel leaves the FIFO.
- done, out, 1, one-cycle pulse after the last pixel is accepted downstream.
- sram_ADDR, out, 20, SRAM word address.
- sram_DQ, inout, 16, SRAM data bus; always high-Z because this block never writes.
- sram_CE_N, out, 1, chip enable, active low.
- sram_OE_N, out, 1, output enable, active low.
- sram_WE_N, out, 1, write enable; tied high.
- sram_LB_N, out, 1, lower byte enable, active low.
- sram_UB_N, out, 1, upper byte enable, active low.
- px_data, out, 16, RGB565 pixel.
- px_valid, out, 1, pixel available.
- px_ready, in, 1, downstream accepts the pixel.
- px_sop, out, 1, qualifies the first pixel of the frame.
- px_eop, out, 1, qualifies the last pixel of the frame.

Function
REQ-003 FSM states: IDLE, SETUP, CAPTURE, STALL, DRAIN.
REQ-004 IDLE: start=1 latches buf_sel, sets addr = buf_sel ? BUF_STRIDE : 0, clears the pixel counter, and moves to SETUP.
REQ-005 SETUP: drives sram_ADDR=addr with CE_N, OE_N, LB_N and UB_N low, for one cycle.
REQ-006 CAPTURE: registers sram_DQ into the FIFO and increments addr and the pixel counter, giving 2 cycles per word.
REQ-007 After CAPTURE the FSM goes to SETUP if the FIFO has room and words remain, to STALL if the FIFO is full, and to DRAIN after word FRAME_W*FRAME_H-1.
REQ-008 STALL: CE_N and OE_N are high; the FSM returns to SETUP on the first cycle the FIFO is not full.
REQ-009 The full test counts the word in flight, so the FIFO never overflows; a write to a full FIFO is a design error flagged by an assertion.
REQ-010 DRAIN: waits until the FIFO is empty and the final handshake has completed, then pulses done for one cycle and returns to IDLE.
REQ-011 Output handshake: a pixel transfers on px_valid && px_ready; px_data, px_sop and px_eop hold while px_valid && !px_ready.
REQ-012 px_sop is set only on FIFO entry 0 of the frame, and px_eop only on entry FRAME_W*FRAME_H-1; both are stored as FIFO sidebands.
REQ-013 The FIFO is first-word-fall-through; px_valid rises no later than 1 cycle after the first CAPTURE.
REQ-014 A same-cycle FIFO push and pop leaves the occupancy unchanged.
REQ-015 start is ignored while busy=1.
REQ-016 start in the same cycle as done is also ignored.
REQ-017 addr is 20 bits and wraps modulo 2^20; it is not checked against the SRAM size.
REQ-018 The pixel counter is 17 bits wide, covering up to 131071 pixels; the elaboration check requires FRAME_W*FRAME_H <= 2^17-1.
REQ-019 Sustained throughput is 1 pixel per 2 clocks whenever px_ready is constantly high.

Reset
REQ-020 reset=1 forces, on the next clk edge:
- state to IDLE;
- the FIFO to empty;
- px_valid, px_sop, px_eop, busy and done to 0;
- sram_ADDR to 0;
- CE_N, OE_N, LB_N, UB_N and WE_N to 1.
REQ-021 A reset in mid-frame abandons the frame; no eop and no done are produced.
REQ-022 The first start after reset begins a fresh frame, with sop on its first pixel.

Structure
REQ-023 The shared package holds:
- the FSM state enum;
- the RGB565 pixel typedef;
- SRAM_AW=20 and SRAM_DW=16.
REQ-024 There is one sub-module, sync_fifo_fwft: parameterised on width (18 bits = data + sop + eop) and depth, with full, empty and count outputs.
REQ-025 The SRAM control outputs are registered, with no combinational path from px_ready to any sram_* pin.

Verification
REQ-026 Directed scenarios:
- Reset, then start with buf_sel=0 and px_ready=1 on a 4x2 frame -> 8 pixels from addresses 0..7, sop on pixel 0, eop on pixel 7, one done pulse, busy low afterwards.
- buf_sel=1 -> first sram_ADDR observed equals 20'h13000, and the data matches the SRAM model contents.
- px_ready=0 for 40 cycles mid-frame -> reads stall with FIFO count=16, no data is lost or duplicated, and the order is preserved after release.
- start pulsed again while busy, and in the done cycle -> ignored; exactly one frame is output.
- reset asserted at pixel 5 -> all outputs at reset values next cycle; the next start gives sop on pixel 0 from the base address.
- Base 20'hFFFFE with a 4-pixel frame -> addresses FFFFE, FFFFF, 00000, 00001.
